sram_burst_master: RTL
======================

SRAM_BURST_MASTER -- requirements
Module: sram_burst_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, giving the SRAM word-address width (1024 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, giving the SRAM word width.
REQ-003 SHALL have parameter LEN_WIDTH, default 11, giving the burst length width (0..1024 words).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on posedge); rst input 1 (synchronous, active-high).
REQ-005 SHALL have the following command ports: cmd_valid_i input 1 (command offered); cmd_ready_o output 1 (command accepted when both high); cmd_write_i input 1 (1 = stream-to-SRAM, 0 = SRAM-to-stream); cmd_addr_i input ADDR_WIDTH (start address); cmd_len_i input LEN_WIDTH (word count).
REQ-006 SHALL have the following read-stream ports: rd_valid_o output 1; rd_ready_i input 1; rd_data_o output DATA_WIDTH; rd_last_o output 1 (final word of burst).
REQ-007 SHALL have the following write-stream ports: wr_valid_i input 1; wr_ready_o output 1; wr_data_i input DATA_WIDTH.
REQ-008 SHALL have the following SRAM master ports: sram_req_o output 1; sram_we_o output 1; sram_addr_o output ADDR_WIDTH; sram_wdata_o output DATA_WIDTH; sram_rdata_i input DATA_WIDTH (valid the cycle after a read req).
REQ-009 SHALL have the following status ports: busy_o output 1 (state != IDLE); done_o output 1 (one-cycle completion pulse).

Function
REQ-010 SHALL implement states IDLE, READ, WRITE, DONE; cmd_ready_o = (state == IDLE).
REQ-011 On command acceptance SHALL latch addr/len/direction; next state is WRITE if cmd_write_i=1, READ if cmd_write_i=0, DONE if cmd_len_i == 0.
REQ-012 Length 0 SHALL issue no SRAM request and no stream beat; done_o pulses one cycle after acceptance.
REQ-013 WRITE: wr_ready_o = 1; each wr_valid_i beat SHALL drive sram_req_o=1, sram_we_o=1, sram_addr_o=current address, sram_wdata_o=wr_data_i, combinationally in the same cycle.
REQ-014 WRITE SHALL advance the address and decrement remaining count per accepted beat; after the last beat the next state is DONE.
REQ-015 READ SHALL use a 2-entry output FIFO plus an in-flight counter (0..2); a read SHALL be issued (sram_req_o=1, sram_we_o=0) only if issued count < len and (fifo_count + inflight - pop_this_cycle) < 2.
REQ-016 sram_rdata_i SHALL be captured into the FIFO exactly one cycle after each read request; no returned word SHALL be dropped under any rd_ready_i pattern.
REQ-017 With rd_ready_i held high, READ SHALL sustain one word per cycle; first rd_valid_o SHALL appear 2 cycles after acceptance.
REQ-018 rd_data_o/rd_valid_o SHALL present the FIFO head; rd_valid_o, once high, SHALL remain high with stable data until rd_ready_i.
REQ-019 rd_last_o SHALL be high with the beat that is the len-th word popped; after that pop the next state is DONE.
REQ-020 Address SHALL increment by 1 per word modulo 2^ADDR_WIDTH (wraps from max to 0).
REQ-021 DONE SHALL last one cycle with done_o=1, then return to IDLE; commands are not accepted in DONE.
REQ-022 Outside its active state, every handshake output SHALL be 0: wr_ready_o=0 outside WRITE; rd_valid_o=0 when the FIFO is empty; sram_req_o=0 in IDLE/DONE.
REQ-023 sram_we_o SHALL be 0 whenever sram_req_o=0.

Reset
REQ-024 With rst=1 at a clock edge, the state SHALL become IDLE, the FIFO and in-flight counter SHALL be cleared, and all outputs SHALL be 0 except cmd_ready_o=1.
REQ-025 Reset mid-burst SHALL abort the burst with no done_o pulse; an SRAM read returning in the cycle after reset SHALL be discarded.

Verification
REQ-026 Write burst: cmd write addr=0x3FE len=4, wr_valid_i continuous, data A..D -> writes to 0x3FE, 0x3FF, 0x000, 0x001; done_o pulses 1 cycle after beat D.
REQ-027 Read burst: SRAM model preloaded, cmd read addr=0x010 len=8, rd_ready_i=1 -> 8 consecutive beats from cycle +2; rd_last_o only on beat 8; done_o pulses next cycle.
REQ-028 Backpressure: read len=16 with rd_ready_i random 50% -> data order exact, no loss or duplication; never more than 2 outstanding (FIFO + in-flight).
REQ-029 Zero length: cmd len=0 (either direction) -> no sram_req_o, no stream beat; done_o one cycle after acceptance; cmd_ready_o high again the cycle after that.
REQ-030 Reset mid-read: assert rst after 3 words popped of len=10 -> the next cycle shows IDLE, rd_valid_o=0, no done_o; a new read len=2 then completes correctly.

Source files
------------

// File: rtl/sram_burst_master_if.sv
// ---------------------------------------------------------------------------
// sram_burst_master_if
//   Bundles every non-clock/reset signal of sram_burst_master.
//   Signal names keep their _i/_o suffixes as seen from the burst master.
//   Groups:
//     command : cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_addr_i, cmd_len_i
//     read    : rd_valid_o, rd_ready_i, rd_data_o, rd_last_o
//     write   : wr_valid_i, wr_ready_o, wr_data_i
//     sram    : sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_rdata_i
//     status  : busy_o, done_o
//   modport master : the burst master itself
//   modport slave  : everything around it (command source, stream
//                    endpoints, SRAM)
// ---------------------------------------------------------------------------
interface sram_burst_master_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 11
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [LEN_WIDTH-1:0]  cmd_len_i;

    logic                  rd_valid_o;
    logic                  rd_ready_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_last_o;

    logic                  wr_valid_i;
    logic                  wr_ready_o;
    logic [DATA_WIDTH-1:0] wr_data_i;

    logic                  sram_req_o;
    logic                  sram_we_o;
    logic [ADDR_WIDTH-1:0] sram_addr_o;
    logic [DATA_WIDTH-1:0] sram_wdata_o;
    logic [DATA_WIDTH-1:0] sram_rdata_i;

    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        input  rd_ready_i, wr_valid_i, wr_data_i, sram_rdata_i,
        output cmd_ready_o, rd_valid_o, rd_data_o, rd_last_o, wr_ready_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o,
        output busy_o, done_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        output rd_ready_i, wr_valid_i, wr_data_i, sram_rdata_i,
        input  cmd_ready_o, rd_valid_o, rd_data_o, rd_last_o, wr_ready_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o,
        input  busy_o, done_o
    );
endinterface

// File: rtl/sram_burst_master.sv
// ---------------------------------------------------------------------------
// sram_burst_master
//   Moves bursts of words between a single-port synchronous SRAM and a pair
//   of valid/ready streams. A command gives direction, start address and
//   word count; the address wraps modulo 2^ADDR_WIDTH.
//   Ports:
//     clk  - clock, all logic on the rising edge
//     rst  - synchronous active-high reset (aborts any burst, no done pulse)
//     bus  - sram_burst_master_if.master: command, read stream, write
//            stream, SRAM master and status signals
//   Write bursts pass wr_data_i straight to the SRAM in the beat's cycle.
//   Read bursts keep at most two words outstanding (2-entry FIFO plus the
//   word in flight from the SRAM), which lets reads stream at one word per
//   cycle while never dropping data under backpressure.
// ---------------------------------------------------------------------------
module sram_burst_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 11
) (
    input  logic clk,
    input  logic rst,
    sram_burst_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  issue_left_reg;   // reads still to be requested
    logic [LEN_WIDTH-1:0]  remaining_reg;    // words still to be transferred
    logic                  fifo_rd_ptr_reg;
    logic                  fifo_wr_ptr_reg;
    logic [1:0]            fifo_count_reg;
    logic [1:0]            inflight_reg;     // read issued last cycle, data on sram_rdata_i now

    logic                  wr_beat;
    logic                  rd_valid;
    logic                  rd_pop;
    logic                  rd_issue;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  last_word;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_empty = (fifo_count_reg == 2'd0);
    assign wr_beat    = (state_reg == S_WRITE) && bus.wr_valid_i;
    // The returning word is offered directly when the FIFO is empty, which
    // gives the two-cycle command-to-first-beat latency.
    assign rd_valid   = (state_reg == S_READ) && (!fifo_empty || (inflight_reg != 2'd0));
    assign rd_pop     = rd_valid && bus.rd_ready_i;
    // Words held after this cycle if nothing new is requested; a new read is
    // only allowed while that leaves room for its returning word.
    assign occupancy  = {1'b0, fifo_count_reg} + {1'b0, inflight_reg} - {2'b00, rd_pop};
    assign rd_issue   = (state_reg == S_READ) && (issue_left_reg != '0) && (occupancy < 3'd2);
    assign fifo_pop   = rd_pop && !fifo_empty;
    // A returning word is stored unless it bypasses straight to the consumer.
    assign fifo_push  = (inflight_reg != 2'd0) && !(fifo_empty && rd_pop);
    assign last_word  = (remaining_reg == LEN_ONE);

    // Two FIFO slots, written alternately by the write pointer.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (fifo_push && (fifo_wr_ptr_reg == 1'(gi))) begin
                    data_reg <= bus.sram_rdata_i;
                end
            end
        end
    endgenerate

    assign head_data = fifo_rd_ptr_reg ? g_slot[1].data_reg : g_slot[0].data_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    if (bus.cmd_len_i == '0) begin
                        state_next = S_DONE;
                    end else if (bus.cmd_write_i) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_beat && last_word) begin
                    state_next = S_DONE;
                end
            end
            S_READ: begin
                if (rd_pop && last_word) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Burst counters, address and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg        <= '0;
            issue_left_reg  <= '0;
            remaining_reg   <= '0;
            inflight_reg    <= 2'd0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_count_reg  <= 2'd0;
        end else begin
            if (state_reg == S_IDLE) begin
                if (bus.cmd_valid_i) begin
                    addr_reg       <= bus.cmd_addr_i;
                    issue_left_reg <= bus.cmd_len_i;
                    remaining_reg  <= bus.cmd_len_i;
                end
            end else begin
                if (wr_beat || rd_issue) begin
                    addr_reg <= addr_reg + ADDR_WIDTH'(1);
                end
                if (rd_issue) begin
                    issue_left_reg <= issue_left_reg - LEN_ONE;
                end
                if (wr_beat || rd_pop) begin
                    remaining_reg <= remaining_reg - LEN_ONE;
                end
            end
            inflight_reg <= {1'b0, rd_issue};
            if (fifo_push) begin
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            fifo_count_reg <= fifo_count_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // Outputs; address/data buses are zeroed whenever they carry nothing
    always_comb begin
        bus.cmd_ready_o  = (state_reg == S_IDLE);
        bus.busy_o       = (state_reg != S_IDLE);
        bus.done_o       = (state_reg == S_DONE);
        bus.wr_ready_o   = (state_reg == S_WRITE);
        bus.sram_req_o   = wr_beat || rd_issue;
        bus.sram_we_o    = wr_beat;
        bus.sram_addr_o  = (wr_beat || rd_issue) ? addr_reg : '0;
        bus.sram_wdata_o = wr_beat ? bus.wr_data_i : '0;
        bus.rd_valid_o   = rd_valid;
        bus.rd_data_o    = '0;
        if (rd_valid) begin
            bus.rd_data_o = fifo_empty ? bus.sram_rdata_i : head_data;
        end
        bus.rd_last_o    = rd_valid && last_word;
    end
endmodule
